div_iter: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 24 ++
 rtl/div_iter.sv | 117 +++++++++++
 tb/tb_div_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, the
// divide-by-zero quotient pattern and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUO = '1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and keep the difference only if it stayed non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic        [WIDTH:0] shifted;
    logic signed [WIDTH:0] trial;

    // rem_in < divisor holds, so the difference always fits in WIDTH+1 signed bits.
    assign shifted = {rem_in, dvd_msb};
    assign trial   = signed'(shifted - {1'b0, divisor});
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction in a final cycle, results held until the next completion.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int CNT_W = clog2(WIDTH);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_p;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic             b_zero;

    assign b_zero = (b == '0);
    assign busy   = (state != IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_p),
        .dvd_msb (dvd[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !b_zero) state_next = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and visible results are reset; working operands are not.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            quo      <= DIV_ZERO_QUO[WIDTH-1:0];
                            rem      <= a;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quo      <= sign_q ? -dvd : dvd;
                    rem      <= sign_r ? -rem_p : rem_p;
                    div_zero <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The dividend register shifts out dividend bits and fills with quotient bits.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start && !b_zero) begin
                    dvd    <= (sign && a[WIDTH-1]) ? -a : a;
                    dvs    <= (sign && b[WIDTH-1]) ? -b : b;
                    sign_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r <= sign & a[WIDTH-1];
                    rem_p  <= '0;
                end
            end
            RUN: begin
                rem_p <= step_rem;
                dvd   <= {dvd[WIDTH-2:0], step_bit};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including completion latency.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         div_zero;

    div_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint lx, ly, lq, lr;
        if (y == '0) begin
            e.q  = '1;
            e.r  = x;
            e.dz = 1'b1;
        end else begin
            if (sg) begin
                lx = longint'($signed(x));
                ly = longint'($signed(y));
            end else begin
                lx = longint'({32'b0, x});
                ly = longint'({32'b0, y});
            end
            lq   = lx / ly;
            lr   = lx % ly;
            e.q  = lq[W-1:0];
            e.r  = lr[W-1:0];
            e.dz = 1'b0;
        end
        e.due = 0;
        return e;
    endfunction

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue_exp(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.due = cyc + 1 + ((y == '0) ? 0 : W + 1);
        sb.push_back(e);
        sign  = sg;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(sg, x, y);
        issue_exp(sg, x, y, e.q, e.r, e.dz);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (k == 200) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 100) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done=0, required 1");
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("done_single_pulse", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: quo=%0h rem=%0h, required no done", quo, rem);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quo", 64'(quo), 64'(e.q));
                chk("rem", 64'(rem), 64'(e.r));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
        prev_done = done;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quo", 64'(quo), 64'd0);
        chk("rst_rem", 64'(rem), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);

        @(negedge clk);
        issue_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) n++;
        end
        chk("busy_cycles", 64'(n), 64'd33);

        wait_idle();
        issue_exp(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        issue_exp(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_idle();
        issue_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        wait_idle();
        issue_exp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        wait_idle();
        issue_exp(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        @(negedge clk);
        chk("div0_busy", 64'(busy), 64'd0);
        wait_idle();
        issue_exp(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_idle();

        // start while busy is ignored; start in the done cycle is accepted
        issue_exp(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        sign = 1'b0; a = 32'd9; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        issue_exp(1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0);
        wait_idle();

        // reset mid-operation: abort with no done pulse afterwards
        issue(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_quo", 64'(quo), 64'd0);
        chk("midrst_rem", 64'(rem), 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 120; i++) begin
            logic [W-1:0] x, y;
            logic         sg;
            x  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 15));
                2:       y = '1;
                3:       y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(sg, x, y);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
